// File: rtl/i2c_pkg.sv
// Shared types and constants for the multi-byte I2C master.
// Holds the FSM states, the quarter-phase codes and the R/W bit encoding.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_RACK,
    S_STOP
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-phase timing for the I2C bit period.
// Freezes while SCL is released but the bus still reads low (clock stretching).
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       scl_oe,
  input  logic       scl_in,
  output logic [1:0] phase,
  output logic       tick_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          hold_c;

  assign hold_c = !scl_oe && !scl_in;
  assign tick_c = en && !hold_c && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!hold_c) begin
      if (tick_c) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_multi.sv
// Multi-byte I2C master: START, address, N write or read bytes, STOP.
// Bus drive and handshake outputs are registered from the current state and phase.
module i2c_master_multi
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_BYTES = 4,
  localparam int unsigned LW       = $clog2(MAX_BYTES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          read_write,
  input  logic [6:0]    addr,
  input  logic [LW-1:0] len,
  input  logic [7:0]    data_write,
  output logic          wr_req,
  output logic [7:0]    data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          nack,
  output logic          scl_oe,
  output logic          sda_oe,
  input  logic          scl_in,
  input  logic          sda_in
);

  state_e              state, state_d;
  logic [BYTE_W-1:0]   shreg, shreg_d;
  logic [2:0]          bit_cnt, bit_cnt_d;
  logic [LW-1:0]       bytes_left, bytes_left_d;
  logic                is_read, is_read_d;
  logic                ack_bit, ack_bit_d;
  logic                busy_d, done_d, nack_d, wr_req_d, rd_valid_d;
  logic [BYTE_W-1:0]   data_d;
  logic                scl_oe_d, sda_oe_d;
  logic [LW-1:0]       len_eff_c;
  logic [1:0]          phase;
  logic                tick_c, end_bit_c, sample_c;

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (state != S_IDLE),
    .scl_oe (scl_oe),
    .scl_in (scl_in),
    .phase  (phase),
    .tick_c (tick_c)
  );

  assign end_bit_c = tick_c && (phase == Q3);
  assign sample_c  = tick_c && (phase == Q2);

  // Zero means one byte; anything above the buffer depth is clamped.
  always_comb begin
    len_eff_c = len;
    if (len == '0) begin
      len_eff_c = LW'(1);
    end else if (len > LW'(MAX_BYTES)) begin
      len_eff_c = LW'(MAX_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      is_read    <= 1'b0;
      ack_bit    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      wr_req     <= 1'b0;
      rd_valid   <= 1'b0;
      data       <= '0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_cnt    <= bit_cnt_d;
      bytes_left <= bytes_left_d;
      is_read    <= is_read_d;
      ack_bit    <= ack_bit_d;
      busy       <= busy_d;
      done       <= done_d;
      nack       <= nack_d;
      wr_req     <= wr_req_d;
      rd_valid   <= rd_valid_d;
      data       <= data_d;
      scl_oe     <= scl_oe_d;
      sda_oe     <= sda_oe_d;
    end
  end

  always_comb begin
    state_d      = state;
    shreg_d      = shreg;
    bit_cnt_d    = bit_cnt;
    bytes_left_d = bytes_left;
    is_read_d    = is_read;
    ack_bit_d    = ack_bit;
    busy_d       = busy;
    nack_d       = nack;
    data_d       = data;
    done_d       = 1'b0;
    wr_req_d     = 1'b0;
    rd_valid_d   = 1'b0;
    scl_oe_d     = (state != S_IDLE) && (phase <= Q1);
    sda_oe_d     = 1'b0;

    case (state)
      S_IDLE: begin
        scl_oe_d = 1'b0;
        if (start) begin
          state_d      = S_START;
          busy_d       = 1'b1;
          nack_d       = 1'b0;
          shreg_d      = {addr, read_write};
          is_read_d    = (read_write == RW_READ);
          bytes_left_d = len_eff_c;
          bit_cnt_d    = '0;
        end
      end

      // SDA falls in Q2 with SCL still released, SCL follows in Q3.
      S_START: begin
        scl_oe_d = (phase == Q3);
        sda_oe_d = (phase >= Q2);
        if (end_bit_c) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        sda_oe_d = !shreg[7];
        if (end_bit_c) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = S_ADDR_ACK;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
            shreg_d   = {shreg[6:0], 1'b0};
          end
        end
      end

      // The requested byte is on data_write while wr_req is high; drive its MSB directly.
      S_WDATA: begin
        sda_oe_d = wr_req ? !data_write[7] : !shreg[7];
        if (wr_req) begin
          shreg_d = data_write;
        end
        if (end_bit_c) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = S_WACK;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
            shreg_d   = {shreg[6:0], 1'b0};
          end
        end
      end

      S_ADDR_ACK, S_WACK: begin
        if (sample_c) begin
          ack_bit_d = sda_in;
        end
        if (end_bit_c) begin
          if (ack_bit) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (state == S_ADDR_ACK) begin
            state_d  = is_read ? S_RDATA : S_WDATA;
            wr_req_d = !is_read;
          end else if (bytes_left == LW'(1)) begin
            state_d = S_STOP;
          end else begin
            bytes_left_d = bytes_left - LW'(1);
            state_d      = S_WDATA;
            wr_req_d     = 1'b1;
          end
        end
      end

      S_RDATA: begin
        if (sample_c) begin
          shreg_d = {shreg[6:0], sda_in};
          if (bit_cnt == 3'd7) begin
            data_d     = {shreg[6:0], sda_in};
            rd_valid_d = 1'b1;
          end
        end
        if (end_bit_c) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = S_RACK;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end

      S_RACK: begin
        sda_oe_d = (bytes_left != LW'(1));
        if (end_bit_c) begin
          if (bytes_left == LW'(1)) begin
            state_d = S_STOP;
          end else begin
            bytes_left_d = bytes_left - LW'(1);
            state_d      = S_RDATA;
          end
        end
      end

      // SDA held low through Q2 so it rises only after SCL is released.
      S_STOP: begin
        sda_oe_d = (phase != Q3);
        if (end_bit_c) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/i2c_master_multi.md
I2C_MASTER_MULTI -- requirements
Module: i2c_master_multi

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period (minimum 2).
REQ-002 SHALL have parameter MAX_BYTES, default 4: maximum data bytes per transfer; LW = $clog2(MAX_BYTES)+1.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  transfer request, accepted only when busy=0.
REQ-006 read_write  in  1  1 = read from slave, 0 = write to slave; sampled with start.
REQ-007 addr  in  7  slave address; sampled with start.
REQ-008 len  in  LW  byte count 1..MAX_BYTES; sampled with start.
REQ-009 data_write  in  8  write byte; sampled in the cycle wr_req=1.
REQ-010 wr_req  out  1  one-cycle pulse requesting the next write byte.
REQ-011 data  out  8  last received read byte; held until the next byte.
REQ-012 rd_valid  out  1  one-cycle pulse when data updates.
REQ-013 busy  out  1  high from start acceptance to end of STOP.
REQ-014 done  out  1  one-cycle pulse at end of STOP.
REQ-015 nack  out  1  sticky slave-NACK flag; cleared on next accepted start.
REQ-016 scl_oe / sda_oe  out  1 each  1 = pull line low, 0 = release (open drain).
REQ-017 scl_in / sda_in  in  1 each  sampled bus line levels.

Function
REQ-018 Bit period = 4 quarters of CLK_DIV clocks: SCL low for Q0–Q1, released for Q2–Q3; SDA changes only at Q0 start; SDA sampled at end of Q2.
REQ-019 Clock stretching: while SCL is released and scl_in=0, the quarter counter SHALL hold; timing resumes on the first cycle scl_in=1.
REQ-020 FSM states: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP.
REQ-021 IDLE->START on start; START (one bit period) drives SDA low while SCL released, then SCL low.
REQ-022 ADDR shifts {addr, read_write} MSB first, 8 bits; ADDR_ACK releases SDA and samples.
REQ-023 ADDR_ACK: sda_in=1 -> nack=1, go to STOP; else WDATA (write) or RDATA (read).
REQ-024 Write: wr_req pulses once per byte, one cycle before that byte's Q0 of bit 7; byte shifted MSB first; WACK samples; NACK -> nack=1, STOP, remaining bytes skipped; ACK with bytes remaining -> WDATA, else STOP.
REQ-025 Read: RDATA releases SDA, shifts 8 bits MSB first; data/rd_valid update at end of bit 0 sample; RACK drives ACK (SDA low) for all but the last byte, NACK (released) on last, then STOP.
REQ-026 STOP (one bit period): SDA low with SCL low, release SCL, then release SDA; done pulses, busy falls same cycle, return to IDLE.
REQ-027 len=0 SHALL be treated as 1; len>MAX_BYTES SHALL be clamped to MAX_BYTES.
REQ-028 start while busy=1 SHALL be ignored with no effect on the transfer.
REQ-029 Total transfer latency without stretching, start to done: (2 + 9×(1+bytes)) × 4×CLK_DIV clocks (NACK-on-address: bytes=0).
REQ-030 Byte counter SHALL not wrap; transfer ends exactly at the programmed count.

Reset
REQ-031 rst=0 at any clock edge, including mid-transfer: FSM->IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, wr_req=0, rd_valid=0, nack=0, data=8'h00, counters cleared; no STOP generated.

Structure
REQ-032 Package i2c_pkg SHALL hold the FSM state enum, quarter-phase constants and the read/write bit encoding.
REQ-033 Sub-module i2c_clk_gen SHALL generate quarter-phase ticks from CLK_DIV with the stretch hold; FSM, shifters and counters stay in i2c_master_multi.

Verification
REQ-034 Write, CLK_DIV=4, addr=7'h50, len=2, bytes 8'hB3, 8'hBC, slave ACKs -> SDA carries 8'hA0, 8'hB3, 8'hBC; 2 wr_req pulses; done 464 clocks after start; nack=0.
REQ-035 Read, addr=7'h50, len=3, slave returns 8'h11, 8'h22, 8'h33 -> 3 rd_valid pulses with those values; master ACK, ACK, NACK; then STOP.
REQ-036 Address NACK (sda_in released in ADDR_ACK) -> nack=1, zero wr_req, STOP, done 176 clocks after start.
REQ-037 Slave holds scl_in low 20 clocks in first data bit -> done delayed exactly 20 clocks; data unchanged.
REQ-038 rst=0 for one cycle mid-WDATA -> next cycle scl_oe=sda_oe=0, busy=0; a new start then completes normally.
REQ-039 start pulsed while busy, and len=0 -> second start ignored; len=0 transfers exactly 1 byte.
